// File: rtl/iter_int_mul_ctrl.sv
// Sequencer for the iterative shift-and-add multiplier datapath.
// Wraps one multiply in val/rdy handshakes and drives the load/shift/acc/clear strobes.
module iter_int_mul_ctrl #(
   parameter int unsigned NBITS_A = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic in_val,
   output logic in_rdy,
   output logic out_val,
   input  logic out_rdy,
   output logic loadA,
   output logic loadB,
   output logic clrP,
   output logic shiftA,
   output logic shiftB,
   output logic accP,
   output logic busy
);

   localparam int unsigned CNT_W = (NBITS_A > 1) ? $clog2(NBITS_A) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBITS_A - 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10,
      BAD  = 2'b11
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;

   // State and iteration counter; the unused encoding falls back to IDLE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_val) begin
                  state <= CALC;
                  cnt   <= '0;
               end
            end
            CALC: begin
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_LAST) begin
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_rdy) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // Moore decode gated by reset so every output drops the moment reset asserts.
   always_comb begin
      in_rdy  = 1'b0;
      out_val = 1'b0;
      loadA   = 1'b0;
      loadB   = 1'b0;
      clrP    = 1'b0;
      shiftA  = 1'b0;
      shiftB  = 1'b0;
      accP    = 1'b0;
      busy    = 1'b0;
      if (reset) begin
         case (state)
            IDLE: begin
               in_rdy = 1'b1;
               loadA  = in_val;
               loadB  = in_val;
               clrP   = in_val;
            end
            CALC: begin
               accP   = 1'b1;
               shiftA = 1'b1;
               shiftB = 1'b1;
               busy   = 1'b1;
            end
            DONE: begin
               out_val = 1'b1;
               busy    = 1'b1;
            end
            default: begin
               in_rdy = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iter_int_mul_ctrl.sv
// Bench for iter_int_mul_ctrl: a stub 8x32 datapath driven by the strobes,
// a transaction-level model of handshake timing and product, and directed vectors.
module tb_iter_int_mul_ctrl;

   localparam int unsigned NA = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_val;
   logic        out_rdy;
   logic [7:0]  opa;
   logic [31:0] opb;
   logic        in_rdy, out_val, loadA, loadB, clrP, shiftA, shiftB, accP, busy;

   iter_int_mul_ctrl #(.NBITS_A(NA)) dut (
      .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy),
      .out_val(out_val), .out_rdy(out_rdy), .loadA(loadA), .loadB(loadB),
      .clrP(clrP), .shiftA(shiftA), .shiftB(shiftB), .accP(accP), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Datapath stub: shift-and-add registers steered only by the strobes.
   logic [7:0]  ra = '0;
   logic [39:0] rb = '0;
   logic [39:0] rp = '0;
   int          acc_pulses = 0;

   always @(posedge clk) begin
      if (loadA) ra <= opa;
      else if (shiftA) ra <= ra >> 1;
      if (loadB) rb <= {8'd0, opb};
      else if (shiftB) rb <= rb << 1;
      if (clrP) rp <= '0;
      else if (accP && ra[0]) rp <= rp + rb;
      if (loadA) acc_pulses = 0;
      else if (accP) acc_pulses = acc_pulses + 1;
   end

   // Transaction model: accept, NA busy cycles, then a held result until out_rdy.
   int          calc_left = 0;
   bit          done_m = 1'b0;
   logic [39:0] exp_p = '0;
   int          cyc = 0;
   int          acc_cyc = 0;
   int          last_lat = 0;
   int          acc_hist[$];

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         calc_left = 0;
         done_m    = 1'b0;
      end else begin
         cyc++;
         if (done_m) begin
            if (out_rdy) done_m = 1'b0;
         end else if (calc_left > 0) begin
            calc_left--;
            if (calc_left == 0) done_m = 1'b1;
         end else if (in_val) begin
            calc_left = NA;
            exp_p     = 40'(opa) * 40'(opb);
            acc_cyc   = cyc;
            acc_hist.push_back(cyc);
         end
      end
   end

   // Per-cycle comparison of every output against the model, on the falling edge.
   bit prev_ov = 1'b0;
   bit e_calc, e_done, e_idle;
   always @(negedge clk) begin
      e_calc = reset && (calc_left > 0);
      e_done = reset && done_m;
      e_idle = reset && !e_calc && !e_done;
      chk("in_rdy",  64'(in_rdy),  64'(e_idle));
      chk("out_val", 64'(out_val), 64'(e_done));
      chk("busy",    64'(busy),    64'(e_calc || e_done));
      chk("loadA",   64'(loadA),   64'(e_idle && in_val));
      chk("loadB",   64'(loadB),   64'(e_idle && in_val));
      chk("clrP",    64'(clrP),    64'(e_idle && in_val));
      chk("accP",    64'(accP),    64'(e_calc));
      chk("shiftA",  64'(shiftA),  64'(e_calc));
      chk("shiftB",  64'(shiftB),  64'(e_calc));
      chk("strobe_eq",  64'((loadA == loadB) && (loadB == clrP)), 64'd1);
      chk("clr_and_acc", 64'(clrP & accP), 64'd0);
      chk("load_and_shift", 64'(loadA & shiftA), 64'd0);
      if (e_done) chk("product", 64'(rp), 64'(exp_p));
      if (e_done && out_rdy) chk("acc_pulses", 64'(acc_pulses), 64'(NA));
      if (out_val && !prev_ov) last_lat = cyc - acc_cyc;
      prev_ov = out_val;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present an operand pair and return just after the accepting edge; in_val stays high.
   task automatic accept(input logic [7:0] a, input logic [31:0] b);
      bit hit;
      hit    = 1'b0;
      opa    = a;
      opb    = b;
      in_val = 1'b1;
      for (int i = 0; i < 40 && !hit; i++) begin
         @(negedge clk);
         hit = in_rdy;
         @(posedge clk);
         #1;
      end
      chk("accept_timeout", 64'(hit), 64'd1);
   endtask

   // Return just after the edge that completes the output handshake.
   task automatic finish_op();
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 40 && !hit; i++) begin
         @(negedge clk);
         hit = out_val && out_rdy;
         @(posedge clk);
         #1;
      end
      chk("done_timeout", 64'(hit), 64'd1);
   endtask

   initial begin
      bit seen;
      reset   = 1'b0;
      in_val  = 1'b0;
      out_rdy = 1'b1;
      opa     = 8'd3;
      opb     = 32'd5;
      repeat (3) tick();
      chk("rst_in_rdy", 64'(in_rdy), 64'd0);
      chk("rst_busy",   64'(busy),   64'd0);

      // in_val raised during reset must not produce load strobes.
      in_val = 1'b1;
      tick();
      chk("rst_loadA_gated", 64'(loadA), 64'd0);
      in_val = 1'b0;
      reset  = 1'b1;
      #1;
      chk("rdy_after_rst", 64'(in_rdy), 64'd1);
      tick();

      // Basic multiply
      accept(8'd3, 32'd5);
      in_val = 1'b0;
      finish_op();
      chk("lat_basic",   64'(last_lat), 64'd8);
      chk("prod_basic",  64'(rp),       64'd15);
      chk("model_basic", 64'(exp_p),    64'd15);
      chk("rdy_after_done", 64'(in_rdy), 64'd1);

      // Extremes
      accept(8'hFF, 32'hFFFF_FFFF);
      in_val = 1'b0;
      finish_op();
      chk("prod_max",  64'(rp),    64'h00FE_FFFF_FF01);
      chk("model_max", 64'(exp_p), 64'h00FE_FFFF_FF01);
      accept(8'd0, 32'h1234);
      in_val = 1'b0;
      finish_op();
      chk("prod_zero", 64'(rp), 64'd0);
      chk("acc_zero",  64'(acc_pulses), 64'd8);

      // Output backpressure with ignored in_val pulses
      out_rdy = 1'b0;
      accept(8'd7, 32'd9);
      in_val = 1'b0;
      seen   = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         seen = out_val;
      end
      chk("bp_seen", 64'(seen), 64'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         in_val = ~in_val;
         opa    = 8'hAA;
         chk("bp_val",  64'(out_val), 64'd1);
         chk("bp_rdy",  64'(in_rdy),  64'd0);
         chk("bp_prod", 64'(rp),      64'd63);
      end
      in_val  = 1'b0;
      out_rdy = 1'b1;
      finish_op();
      chk("bp_idle", 64'(in_rdy), 64'd1);

      // Back-to-back with in_val held high
      accept(8'd2, 32'd3);
      opa = 8'd4;
      opb = 32'd5;
      finish_op();
      chk("b2b_prod1", 64'(rp), 64'd6);
      accept(8'd4, 32'd5);
      in_val = 1'b0;
      finish_op();
      chk("b2b_prod2", 64'(rp), 64'd20);
      chk("b2b_spacing", 64'(acc_hist[$] - acc_hist[$-1]), 64'd10);

      // Reset in the fourth CALC cycle
      accept(8'd2, 32'd2);
      in_val = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_busy",   64'(busy),   64'd0);
      chk("arst_accP",   64'(accP),   64'd0);
      chk("arst_shiftA", 64'(shiftA), 64'd0);
      chk("arst_in_rdy", 64'(in_rdy), 64'd0);
      chk("arst_outval", 64'(out_val), 64'd0);
      repeat (2) tick();
      reset = 1'b1;
      #1;
      chk("arst_rdy_after", 64'(in_rdy), 64'd1);
      chk("arst_idle",      64'(busy),   64'd0);
      tick();
      accept(8'd2, 32'd2);
      in_val = 1'b0;
      finish_op();
      chk("arst_prod", 64'(rp), 64'd4);

      repeat (2) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

endmodule
